// File: rtl/wsg_pkg.sv
// wsg_pkg: shared types and register-map constants for the Namco WSG sound engine.
package wsg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        ACC
    } wsg_state_t;

    localparam int NUM_VOICES = 3;
    localparam int PHASE_W    = 20;

    localparam logic [4:0] REG_WAVE     = 5'h05;
    localparam logic [4:0] REG_FREQ_LO  = 5'h10;
    localparam logic [4:0] REG_VOL      = 5'h15;
    localparam logic [4:0] VOICE_STRIDE = 5'd5;

    function automatic logic [4:0] voice_offset(input logic [1:0] v);
        return 5'(v) * VOICE_STRIDE;
    endfunction

endpackage

// File: rtl/wsg_regfile.sv
// wsg_regfile: 32x4 WSG sound register file with a combinational per-voice view
// of wave select, volume and 20-bit frequency.
module wsg_regfile
    import wsg_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               we,
    input  logic [4:0]         addr,
    input  logic [3:0]         din,
    input  logic [1:0]         voice,
    output logic [3:0]         wave,
    output logic [3:0]         volume,
    output logic [PHASE_W-1:0] freq
);

    logic [3:0] regs [32];
    logic [4:0] off;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 4'h0;
            end
        end else if (we) begin
            regs[addr] <= din;
        end
    end

    // Only voice 0 owns a low frequency nibble (0x10); the other voices read it as zero.
    always_comb begin
        off    = voice_offset(voice);
        wave   = regs[REG_WAVE + off];
        volume = regs[REG_VOL + off];
        freq   = {regs[REG_FREQ_LO + off + 5'd4],
                  regs[REG_FREQ_LO + off + 5'd3],
                  regs[REG_FREQ_LO + off + 5'd2],
                  regs[REG_FREQ_LO + off + 5'd1],
                  (voice == 2'd0) ? regs[REG_FREQ_LO] : 4'h0};
    end

endmodule

// File: rtl/wsg_sequencer.sv
// wsg_sequencer: time-slices three WSG voices over one wave PROM read and one
// multiply-accumulate path, producing a signed mixed sample every third slot.
module wsg_sequencer
    import wsg_pkg::*;
#(
    parameter int CLK_HZ  = 47828000,
    parameter int SLOT_HZ = 72000,
    parameter int OUT_W   = 10
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    reg_we,
    input  logic [4:0]              reg_addr,
    input  logic [3:0]              reg_din,
    input  logic                    sound_en,
    output logic                    prom_rd,
    output logic [7:0]              prom_addr,
    output logic                    prom_sel,
    input  logic [3:0]              prom_data,
    output logic signed [OUT_W-1:0] sample,
    output logic                    sample_valid
);

    localparam int DIV   = CLK_HZ / SLOT_HZ - 1;
    localparam int CNT_W = $clog2(DIV + 1);

    if (DIV < 4) begin : g_div_check
        $error("wsg_sequencer: CLK_HZ/SLOT_HZ-1 must be at least 4");
    end
    if (OUT_W < 10) begin : g_width_check
        $error("wsg_sequencer: OUT_W must be at least 10");
    end

    wsg_state_t               state_q, state_d;
    logic [CNT_W-1:0]         div_cnt;
    logic                     tick;
    logic [1:0]               voice;
    logic [PHASE_W-1:0]       phase [NUM_VOICES];
    logic [3:0]               vol_l;
    logic [PHASE_W-1:0]       freq_l;
    logic signed [OUT_W-1:0]  acc;
    logic signed [4:0]        samp_s;
    logic signed [OUT_W-1:0]  term;
    logic signed [OUT_W-1:0]  acc_sum;
    logic                     slot_start;
    logic                     slot_acc;
    logic [3:0]               rf_wave;
    logic [3:0]               rf_volume;
    logic [PHASE_W-1:0]       rf_freq;

    wsg_regfile u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .we     (reg_we),
        .addr   (reg_addr),
        .din    (reg_din),
        .voice  (voice),
        .wave   (rf_wave),
        .volume (rf_volume),
        .freq   (rf_freq)
    );

    assign tick = (div_cnt == CNT_W'(DIV));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_start = 1'b0;
        slot_acc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d    = FETCH;
                    slot_start = 1'b1;
                end
            end
            FETCH:   state_d = WAIT;
            WAIT:    state_d = ACC;
            ACC: begin
                state_d  = IDLE;
                slot_acc = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // PROM nibble is offset binary; recentre to -8..7 and weight by the 4-bit volume.
    assign samp_s  = $signed({1'b0, prom_data}) - 5'sd8;
    assign term    = OUT_W'($signed({1'b0, vol_l})) * OUT_W'(samp_s);
    assign acc_sum = acc + term;

    // Voice parameters are captured on the slot-start edge, so a write landing
    // during FETCH is only seen by that voice's next slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prom_rd      <= 1'b0;
            prom_addr    <= '0;
            prom_sel     <= 1'b0;
            vol_l        <= '0;
            freq_l       <= '0;
            voice        <= 2'd0;
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
            end
        end else begin
            prom_rd      <= 1'b0;
            sample_valid <= 1'b0;
            if (slot_start) begin
                prom_rd   <= 1'b1;
                prom_addr <= {rf_wave[2:0], phase[voice][17:13]};
                prom_sel  <= rf_wave[3];
                vol_l     <= rf_volume;
                freq_l    <= rf_freq;
            end
            if (slot_acc) begin
                phase[voice] <= phase[voice] + freq_l;
                if (voice == 2'(NUM_VOICES - 1)) begin
                    voice        <= 2'd0;
                    acc          <= '0;
                    sample       <= sound_en ? acc_sum : '0;
                    sample_valid <= 1'b1;
                end else begin
                    voice <= voice + 2'd1;
                    acc   <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_wsg_sequencer.sv
// tb_wsg_sequencer: table-driven and hand-sequenced checks of the WSG sequencer,
// with a sample scoreboard fed by the stimulus tasks.
module tb_wsg_sequencer;

    localparam int TB_CLK_HZ     = 1440000;
    localparam int TB_SLOT_HZ    = 72000;
    localparam int OUT_W         = 10;
    localparam int DIV           = TB_CLK_HZ / TB_SLOT_HZ - 1;
    localparam int SAMPLE_PERIOD = 3 * (DIV + 1);
    localparam int TIMEOUT       = 4 * SAMPLE_PERIOD;

    typedef struct {
        logic [3:0] vol0;
        logic [3:0] vol1;
        logic [3:0] vol2;
        logic [3:0] prom_val;
        logic       en;
        int         expected;
    } vec_t;

    logic                    clk;
    logic                    resetn;
    logic                    reg_we;
    logic [4:0]              reg_addr;
    logic [3:0]              reg_din;
    logic                    sound_en;
    logic                    prom_rd;
    logic [7:0]              prom_addr;
    logic                    prom_sel;
    logic [3:0]              prom_data;
    logic signed [OUT_W-1:0] sample;
    logic                    sample_valid;

    logic [3:0] prom_const;
    int         exp_q[$];
    int         exp_val;
    int         n_checks;
    int         n_errors;
    vec_t       vecs [10];

    wsg_sequencer #(
        .CLK_HZ  (TB_CLK_HZ),
        .SLOT_HZ (TB_SLOT_HZ),
        .OUT_W   (OUT_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_din      (reg_din),
        .sound_en     (sound_en),
        .prom_rd      (prom_rd),
        .prom_addr    (prom_addr),
        .prom_sel     (prom_sel),
        .prom_data    (prom_data),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PROM model: constant nibble, latched on a read and held until the next one.
    always @(negedge clk) begin
        if (prom_rd) prom_data = prom_const;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && sample_valid && exp_q.size() > 0) begin
            exp_val = exp_q.pop_front();
            checkOutput("sample", int'(sample), exp_val);
        end
    end

    task automatic wait_event(input bit on_sample, input string name, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < TIMEOUT) begin
            @(negedge clk);
            n++;
            if (on_sample ? sample_valid : prom_rd) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput({"timeout_", name}, 0, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checkOutput({"drain_", name}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [3:0] d);
        @(negedge clk);
        reg_we   = 1'b1;
        reg_addr = a;
        reg_din  = d;
        @(negedge clk);
        reg_we   = 1'b0;
    endtask

    // Configures the sample that follows the next sample_valid and queues its expectation.
    task automatic applyStimulus(input vec_t v, input string name);
        bit ok;
        wait_event(1'b1, name, ok);
        prom_const = v.prom_val;
        sound_en   = v.en;
        write_reg(5'h15, v.vol0);
        write_reg(5'h1A, v.vol1);
        write_reg(5'h1F, v.vol2);
        exp_q.push_back(v.expected);
    endtask

    initial begin
        int  rd_idx[$];
        int  sv_idx[$];
        int  n;
        int  first_addr;
        bit  ok;

        n_checks   = 0;
        n_errors   = 0;
        resetn     = 1'b0;
        reg_we     = 1'b0;
        reg_addr   = 5'h00;
        reg_din    = 4'h0;
        sound_en   = 1'b1;
        prom_const = 4'h0;
        prom_data  = 4'h0;
        first_addr = -1;

        vecs[0] = '{4'd15, 4'd0,  4'd0,  4'd15, 1'b1,  105};
        vecs[1] = '{4'd15, 4'd0,  4'd0,  4'd0,  1'b1, -120};
        vecs[2] = '{4'd15, 4'd15, 4'd15, 4'd0,  1'b1, -360};
        vecs[3] = '{4'd15, 4'd15, 4'd15, 4'd0,  1'b0,    0};
        vecs[4] = '{4'd7,  4'd3,  4'd1,  4'd12, 1'b1,   44};
        vecs[5] = '{4'd15, 4'd15, 4'd15, 4'd15, 1'b1,  315};
        vecs[6] = '{4'd0,  4'd0,  4'd0,  4'd5,  1'b1,    0};
        vecs[7] = '{4'd1,  4'd2,  4'd3,  4'd9,  1'b1,    6};
        vecs[8] = '{4'd15, 4'd15, 4'd15, 4'd8,  1'b1,    0};
        vecs[9] = '{4'd10, 4'd5,  4'd0,  4'd3,  1'b1,  -75};

        // Reset state, then slot timing and sample cadence with an idle register file.
        repeat (3) @(negedge clk);
        checkOutput("rst_sample", int'(sample), 0);
        checkOutput("rst_valid", int'(sample_valid), 0);
        checkOutput("rst_prom_rd", int'(prom_rd), 0);
        checkOutput("rst_prom_addr", int'(prom_addr), 0);
        checkOutput("rst_prom_sel", int'(prom_sel), 0);
        resetn = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(0);
        n = 0;
        while (n < TIMEOUT && sv_idx.size() < 2) begin
            @(negedge clk);
            n++;
            if (prom_rd) begin
                if (rd_idx.size() == 0) first_addr = int'(prom_addr);
                rd_idx.push_back(n);
            end
            if (sample_valid) sv_idx.push_back(n);
        end
        checkOutput("t1_rd_count", rd_idx.size(), 6);
        checkOutput("t1_sv_count", sv_idx.size(), 2);
        checkOutput("t1_first_addr", first_addr, 0);
        if (rd_idx.size() >= 3 && sv_idx.size() >= 2) begin
            checkOutput("t1_first_slot", rd_idx[0], DIV + 1);
            checkOutput("t1_slot_spacing", rd_idx[1] - rd_idx[0], DIV + 1);
            checkOutput("t1_latency", sv_idx[0] - rd_idx[2], 3);
            checkOutput("t1_period", sv_idx[1] - sv_idx[0], SAMPLE_PERIOD);
        end
        drain("t1");

        // Voice-0 phase stepping: freq0 = 0x02000 moves phase[17:13] by one per sample.
        write_reg(5'h13, 4'd2);
        for (int k = 0; k < 33; k++) begin
            wait_event(1'b0, "t2_v0", ok);
            checkOutput("t2_phase", int'(prom_addr[4:0]), k % 32);
            wait_event(1'b0, "t2_v1", ok);
            wait_event(1'b0, "t2_v2", ok);
        end

        // Volume rewritten during the voice-0 FETCH cycle only affects the following sample.
        applyStimulus('{4'd15, 4'd1, 4'd0, 4'd15, 1'b1, 112}, "t5_setup");
        wait_event(1'b0, "t5_fetch", ok);
        reg_we   = 1'b1;
        reg_addr = 5'h15;
        reg_din  = 4'h0;
        @(negedge clk);
        reg_we   = 1'b0;
        exp_q.push_back(7);
        drain("t5");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], "table");
        end
        drain("table");

        // Reset asserted during WAIT clears outputs immediately; sequencing restarts at voice 0.
        write_reg(5'h05, 4'hD);
        wait_event(1'b0, "t6_fetch", ok);
        @(posedge clk);
        #1;
        checkOutput("t6_pre_sel", int'(prom_sel), 1);
        checkOutput("t6_pre_wave", int'(prom_addr[7:5]), 5);
        checkOutput("t6_pre_sample", int'(sample), -75);
        resetn = 1'b0;
        #1;
        checkOutput("t6_rst_rd", int'(prom_rd), 0);
        checkOutput("t6_rst_addr", int'(prom_addr), 0);
        checkOutput("t6_rst_sel", int'(prom_sel), 0);
        checkOutput("t6_rst_sample", int'(sample), 0);
        checkOutput("t6_rst_valid", int'(sample_valid), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        write_reg(5'h05, 4'd1);
        write_reg(5'h0A, 4'd2);
        write_reg(5'h0F, 4'd3);
        write_reg(5'h13, 4'd2);
        wait_event(1'b0, "t6_v0", ok);
        checkOutput("t6_v0_addr", int'(prom_addr), 8'h20);
        checkOutput("t6_v0_sel", int'(prom_sel), 0);
        wait_event(1'b0, "t6_v1", ok);
        checkOutput("t6_v1_addr", int'(prom_addr), 8'h40);
        wait_event(1'b0, "t6_v2", ok);
        checkOutput("t6_v2_addr", int'(prom_addr), 8'h60);
        exp_q.push_back(0);
        wait_event(1'b0, "t6_v0b", ok);
        checkOutput("t6_v0_next", int'(prom_addr), 8'h21);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
